// File: rtl/seq_bit_serializer.sv
// Parallel-in/serial-out stage: buffers WIDTH-bit words in a small FIFO and
// emits them MSB-first, one bit per clock, with no gap between queued words.
module seq_bit_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    state_e           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             out_q;
    logic             out_valid_q;

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             last_bit;
    logic [WIDTH-1:0] head_word;

    // Extra pointer MSB distinguishes full (wrapped once) from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign last_bit  = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    assign push      = din_valid && !fifo_full;
    assign pop       = !fifo_empty && ((state_q == ST_IDLE) || last_bit);
    assign head_word = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path can infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        word_cnt_d = word_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (last_bit) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            word_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            out_q       <= IDLE_BIT;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            word_cnt_q <= word_cnt_d;
            if (pop) begin
                state_q     <= ST_SHIFT;
                sr_q        <= head_word;
                bit_cnt_q   <= CW'(WIDTH - 1);
                out_q       <= head_word[WIDTH-1];
                out_valid_q <= 1'b1;
            end else if (state_q == ST_SHIFT && bit_cnt_q != '0) begin
                sr_q      <= sr_q << 1;
                bit_cnt_q <= bit_cnt_q - CW'(1);
                out_q     <= sr_q[WIDTH-2];
            end else if (state_q == ST_SHIFT) begin
                state_q     <= ST_IDLE;
                out_q       <= IDLE_BIT;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign din_ready = !fifo_full;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = !fifo_empty || (state_q == ST_SHIFT);
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: accepted words become a queue of
// expected serial bits; a negedge monitor pops and compares every data bit.
module tb_seq_bit_serializer;

    localparam int   WIDTH    = 8;
    localparam int   DEPTH    = 4;
    localparam logic IDLE_BIT = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic [15:0]      word_cnt;

    seq_bit_serializer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .IDLE_BIT(IDLE_BIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   acc;
        logic last;
    } exp_bit_t;

    exp_bit_t    sb[$];
    int          cyc     = 0;
    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] exp_cnt = 16'd0;
    bit          mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int hits16(input logic [15:0] v);
        int n = 0;
        for (int i = 15; i >= 4; i--) begin
            if (v[i -: 5] == 5'b11011) n++;
        end
        return n;
    endfunction

    // Monitor: busy tracks outstanding bits, data bits follow the queue, idle
    // fill is IDLE_BIT, and a word queued for two or more edges is never left waiting.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("busy", busy, 32'(sb.size() != 0));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("extra_bit", out_valid, 0);
                end else begin
                    exp_bit_t e;
                    e = sb.pop_front();
                    check("serial_bit", out, e.b);
                    if (e.last) exp_cnt = exp_cnt + 16'd1;
                end
            end else begin
                check("idle_fill", out, IDLE_BIT);
                if (sb.size() != 0 && sb[0].acc <= cyc - 1) check("gap_or_late", out_valid, 1);
            end
        end
    end

    // Entered at a negedge; leaves din_valid high at the negedge after acceptance.
    task automatic send(input logic [WIDTH-1:0] w);
        int g = 0;
        din       = w;
        din_valid = 1'b1;
        while (!din_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!din_ready) begin
            check("send_timeout", din_ready, 1);
            din_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        for (int i = WIDTH - 1; i >= 0; i--) sb.push_back('{w[i], cyc, (i == 0)});
        @(negedge clk);
    endtask

    task automatic drop_valid();
        din_valid = 1'b0;
        din       = WIDTH'($urandom);
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while ((busy || sb.size() != 0) && g < 400) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_idle"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_word_cnt"}, word_cnt, exp_cnt);
    endtask

    task automatic capture8(input string tag, input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] obs;
        logic             vall;
        vall = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            obs[WIDTH-1-i] = out;
            vall           = vall & out_valid;
            @(negedge clk);
        end
        check({tag, "_bits"}, obs, w);
        check({tag, "_valid_run"}, vall, 1);
        check({tag, "_after_valid"}, out_valid, 0);
        check({tag, "_after_out"}, out, IDLE_BIT);
    endtask

    initial begin
        logic [15:0] obs16;
        logic        vall;

        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        #2;
        check("rst_out", out, IDLE_BIT);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_word_cnt", word_cnt, 0);
        #8;
        rst = 1'b0;
        #3;
        @(negedge clk);
        mon_en = 1'b1;
        check("rst_ready", din_ready, 1);

        // 1: single word, latency and exact bit pattern
        send(8'hD8);
        drop_valid();
        check("t1_no_bypass", out_valid, 0);
        @(negedge clk);
        capture8("t1", 8'hD8);
        drain("t1");
        check("t1_cnt_one", word_cnt, 16'd1);

        // 2: back-to-back words stream without a gap
        send(8'hDB);
        send(8'h6C);
        drop_valid();
        vall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            obs16[15-i] = out;
            vall        = vall & out_valid;
            @(negedge clk);
        end
        check("t2_stream", obs16, 16'hDB6C);
        check("t2_no_gap", vall, 1);
        check("t2_detector_hits", hits16(obs16), 4);
        drain("t2");

        // 3: backpressure with a held word
        for (int w = 1; w <= 6; w++) begin
            if (w == 6) check("t3_full", din_ready, 0);
            send(WIDTH'(w));
        end
        drop_valid();
        drain("t3");

        // 4: push on the same edge a word completes with two queued
        send(8'hA1);
        send(8'hB2);
        send(8'hC3);
        drop_valid();
        repeat (6) @(negedge clk);
        check("t4_ready_before", din_ready, 1);
        send(8'hD4);
        drop_valid();
        check("t4_ready_after", din_ready, 1);
        drain("t4");

        // 5: asynchronous reset in the middle of a word
        send(8'hFF);
        drop_valid();
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        exp_cnt = 16'd0;
        #1;
        check("t5_out", out, IDLE_BIT);
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_word_cnt", word_cnt, 0);
        #10;
        rst = 1'b0;
        #1;
        @(negedge clk);
        check("t5_ready", din_ready, 1);
        send(8'hA5);
        drop_valid();
        check("t5_no_bypass", out_valid, 0);
        @(negedge clk);
        capture8("t5", 8'hA5);
        drain("t5");

        // 6: word counter wrap
        force dut.word_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.word_cnt_q;
        exp_cnt = 16'hFFFF;
        send(WIDTH'($urandom));
        drop_valid();
        drain("t6a");
        check("t6_wrap_zero", word_cnt, 16'h0000);
        send(WIDTH'($urandom));
        drop_valid();
        drain("t6b");
        check("t6_wrap_one", word_cnt, 16'h0001);

        // 7: randomized traffic with idle gaps and FIFO pressure
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
            if (gap != 0) begin
                drop_valid();
                repeat (gap) @(negedge clk);
            end
            send(WIDTH'($urandom));
        end
        drop_valid();
        drain("t7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
